// File: rtl/lab_readout_engine.sv
// lab_readout_engine: polls LAB done flags and streams each finished LAB RAM as a framed packet
module lab_readout_engine #(
  parameter int NWORDS = 1536,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  enable_i,
  output logic [12:0] addr_o,
  input  logic [31:0] dat_i,
  input  logic        done_i,
  output logic [31:0] tdata_o,
  output logic        tvalid_o,
  input  logic        tready_i,
  output logic        tlast_o,
  output logic        busy_o,
  output logic [3:0]  lab_sent_o
);
  localparam int AW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [CW:0] DEPTH = FIFO_D[CW:0];
  typedef enum logic [1:0] {POLL, HDR, READ, DRAIN} state_t;
  state_t state, state_n;
  logic [1:0] ptr;
  logic settle;
  logic [3:0] sent;
  logic [9:0] evcnt;
  logic [10:0] rd_addr;
  logic [RD_LAT-1:0] vpipe, lpipe;
  logic [CW-1:0] cnt, infl;
  logic [AW-1:0] wp, rp;
  logic [32:0] mem [FIFO_D];
  logic [32:0] wdata;
  logic eval, go, credit, issue, last_issue, hdr_push, dat_push, push, pop, pkt_done;
  assign eval = state == POLL && !settle;
  assign go = eval && enable_i[ptr] && done_i && !sent[ptr];
  assign credit = ({1'b0, cnt} + {1'b0, infl}) < DEPTH;
  assign issue = (state == HDR || state == READ) && credit;
  assign last_issue = issue && rd_addr == 11'(NWORDS - 1);
  assign hdr_push = state == HDR && credit;
  assign dat_push = vpipe[RD_LAT-1];
  assign push = hdr_push || dat_push;
  assign pop = tvalid_o && tready_i;
  assign pkt_done = state == DRAIN && pop && tlast_o;
  assign wdata = hdr_push ? {1'b0, 4'hA, ptr, evcnt, 16'(NWORDS)} : {lpipe[RD_LAT-1], dat_i};
  assign tvalid_o = cnt != '0;
  assign tdata_o = tvalid_o ? mem[rp][31:0] : 32'd0;
  assign tlast_o = tvalid_o && mem[rp][32];
  assign busy_o = state != POLL;
  assign addr_o = {ptr, (state == HDR || state == READ) ? rd_addr : 11'd0};
  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= POLL;
    else state <= state_n;
  // Next state; HDR also issues word 0 so data follows the header without a bubble
  always_comb begin
    state_n = state;
    case (state)
      POLL:    state_n = go ? HDR : POLL;
      HDR:     state_n = hdr_push ? (last_issue ? DRAIN : READ) : HDR;
      READ:    state_n = last_issue ? DRAIN : READ;
      DRAIN:   state_n = pkt_done ? POLL : DRAIN;
      default: state_n = POLL;
    endcase
  end
  // Poll pointer with settle cycle, sent flags, event counter, read address, sent pulse
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      ptr <= 2'd0;
      settle <= 1'b1;
      sent <= 4'd0;
      evcnt <= 10'd0;
      rd_addr <= 11'd0;
      lab_sent_o <= 4'd0;
    end else begin
      settle <= 1'b0;
      lab_sent_o <= 4'd0;
      if (eval && !go) begin
        ptr <= ptr + 2'd1;
        settle <= 1'b1;
      end
      if (eval && !done_i) sent[ptr] <= 1'b0;
      if (go) rd_addr <= 11'd0;
      else if (issue) rd_addr <= rd_addr + 11'd1;
      if (pkt_done) begin
        sent[ptr] <= 1'b1;
        lab_sent_o[ptr] <= 1'b1;
        evcnt <= evcnt + 10'd1;
        ptr <= ptr + 2'd1;
        settle <= 1'b1;
      end
    end
  // Outstanding RAM reads: valid/last bits ride a RD_LAT-deep shift register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      vpipe <= '0;
      lpipe <= '0;
      infl <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(issue);
      lpipe <= (lpipe << 1) | RD_LAT'(last_issue);
      infl <= infl + CW'(issue) - CW'(dat_push);
    end
  // Skid FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= (wp == AW'(FIFO_D - 1)) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == AW'(FIFO_D - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // Skid FIFO storage, {last, data}
  always_ff @(posedge clk_i)
    if (push) mem[wp] <= wdata;
endmodule

// File: tb/tb_lab_readout_engine.sv
// tb_lab_readout_engine: directed scenario bench for lab_readout_engine
`timescale 1ns/1ps
module tb_lab_readout_engine;
  localparam int NW = 1536;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b1;
  logic [3:0] enable_i = 4'd0, enable2 = 4'd0;
  logic [12:0] addr_o, addr2;
  logic [31:0] dat_i, dat2, d1;
  logic done_i, done2_i;
  logic [3:0] done_r = 4'd0, done2_r = 4'd0;
  logic [31:0] tdata_o, tdata2;
  logic tvalid_o, tvalid2, tlast_o, tlast2, busy_o, busy2;
  logic tready_i = 1'b1, tready2 = 1'b0;
  logic [3:0] lab_sent_o, lab_sent2, sent2_or;
  logic mix = 1'b0;
  int checks = 0, failures = 0, cyc = 0, nlast = 0, nlast2 = 0;
  logic [31:0] q_data[$], q2_data[$];
  logic q_last[$], q2_last[$];
  int q_cyc[$];
  logic [3:0] q_sent[$];

  lab_readout_engine u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .addr_o(addr_o), .dat_i(dat_i),
    .done_i(done_i), .tdata_o(tdata_o), .tvalid_o(tvalid_o), .tready_i(tready_i),
    .tlast_o(tlast_o), .busy_o(busy_o), .lab_sent_o(lab_sent_o)
  );
  lab_readout_engine #(.RD_LAT(2), .FIFO_D(4)) u_dut2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable2), .addr_o(addr2), .dat_i(dat2),
    .done_i(done2_i), .tdata_o(tdata2), .tvalid_o(tvalid2), .tready_i(tready2),
    .tlast_o(tlast2), .busy_o(busy2), .lab_sent_o(lab_sent2)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [1:0] lab, input logic [10:0] k);
    return mix ? {lab, 19'd0, k} : {21'd0, k};
  endfunction

  assign done_i = done_r[addr_o[12:11]];
  assign done2_i = done2_r[addr2[12:11]];
  always @(posedge clk_i) begin
    dat_i <= word(addr_o[12:11], addr_o[10:0]);
    d1 <= word(addr2[12:11], addr2[10:0]);
    dat2 <= d1;
  end

  always @(negedge clk_i) begin
    if (tvalid_o && tready_i) begin
      q_data.push_back(tdata_o);
      q_last.push_back(tlast_o);
      q_cyc.push_back(cyc);
      if (tlast_o) nlast++;
    end
    if (lab_sent_o != 4'd0) q_sent.push_back(lab_sent_o);
    if (tvalid2 && tready2) begin
      q2_data.push_back(tdata2);
      q2_last.push_back(tlast2);
      if (tlast2) nlast2++;
    end
    sent2_or = sent2_or | lab_sent2;
  end

  task automatic clear_mon();
    q_data.delete(); q_last.delete(); q_cyc.delete(); q_sent.delete();
    q2_data.delete(); q2_last.delete();
    nlast = 0; nlast2 = 0; sent2_or = 4'd0;
  endtask

  task automatic apply_reset();
    @(posedge clk_i); #1 rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n_i = 1'b0;
    #2;
    checks++; if (tvalid_o !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b exp=0", tvalid_o); end
    checks++; if (addr_o !== 13'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    checks++; if (lab_sent_o !== 4'd0) begin failures++; $display("FAIL reset_lab_sent got=%b exp=0000", lab_sent_o); end
    checks++; if (tlast_o !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%0b exp=0", tlast_o); end
    checks++; if (tdata_o !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", tdata_o); end
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic test_disabled();
    int bz = 0;
    clear_mon();
    enable_i = 4'd0; done_r = 4'hF; tready_i = 1'b1;
    repeat (60) begin
      @(negedge clk_i);
      if (busy_o) bz++;
    end
    checks++; if (bz !== 0) begin failures++; $display("FAIL disabled_busy got=%0d exp=0", bz); end
    checks++; if (q_data.size() !== 0) begin failures++; $display("FAIL disabled_output got=%0d exp=0", q_data.size()); end
    @(posedge clk_i); #1 done_r = 4'd0;
    repeat (10) @(posedge clk_i);
  endtask

  task automatic test_single();
    int bad = 0, bada = 0, gap = 0, c = 0;
    logic [3:0] sor = 4'd0;
    @(posedge clk_i); #1;
    clear_mon(); mix = 1'b0; tready_i = 1'b1; done_r = 4'b0100; enable_i = 4'hF;
    while (nlast < 1 && c < 4000) begin
      @(negedge clk_i); c++;
      if (busy_o && addr_o[12:11] !== 2'd2) bada++;
    end
    repeat (3) @(negedge clk_i);
    checks++; if (nlast !== 1) begin failures++; $display("FAIL single_timeout got=%0d exp=1", nlast); end
    checks++; if (q_data.size() !== NW + 1) begin failures++; $display("FAIL single_len got=%0d exp=%0d", q_data.size(), NW + 1); end
    checks++; if (q_data[0] !== 32'hA800_0600) begin failures++; $display("FAIL single_hdr got=%h exp=a8000600", q_data[0]); end
    if (q_last[0] !== 1'b0) bad++;
    for (int k = 0; k < NW && k + 1 < q_data.size(); k++) begin
      if (q_data[k+1] !== {21'd0, 11'(k)} || q_last[k+1] !== (k == NW - 1)) bad++;
      if (q_cyc[k+1] - q_cyc[0] != k + 1) gap++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL single_data got=%0d bad exp=0", bad); end
    checks++; if (gap !== 0) begin failures++; $display("FAIL single_gaps got=%0d exp=0", gap); end
    checks++; if (bada !== 0) begin failures++; $display("FAIL single_addr_lab got=%0d exp=0", bada); end
    foreach (q_sent[i]) sor = sor | q_sent[i];
    checks++; if (q_sent.size() !== 1 || sor !== 4'b0100) begin failures++; $display("FAIL single_lab_sent got=%0d/%b exp=1/0100", q_sent.size(), sor); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b exp=0", busy_o); end
  endtask

  task automatic test_rearm();
    int bad = 0, c = 0;
    clear_mon();
    repeat (200) @(negedge clk_i);
    checks++; if (q_data.size() !== 0) begin failures++; $display("FAIL rearm_no_repeat got=%0d exp=0", q_data.size()); end
    @(posedge clk_i); #1 done_r = 4'd0;
    repeat (20) @(posedge clk_i);
    #1 done_r = 4'b0100;
    while (nlast < 1 && c < 4000) begin
      @(negedge clk_i); c++;
    end
    checks++; if (nlast !== 1) begin failures++; $display("FAIL rearm_timeout got=%0d exp=1", nlast); end
    checks++; if (q_data.size() !== NW + 1) begin failures++; $display("FAIL rearm_len got=%0d exp=%0d", q_data.size(), NW + 1); end
    checks++; if (q_data[0] !== 32'hA801_0600) begin failures++; $display("FAIL rearm_hdr got=%h exp=a8010600", q_data[0]); end
    for (int k = 0; k < NW && k + 1 < q_data.size(); k++)
      if (q_data[k+1] !== {21'd0, 11'(k)}) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rearm_data got=%0d bad exp=0", bad); end
    @(posedge clk_i); #1 done_r = 4'd0;
    repeat (20) @(posedge clk_i);
  endtask

  task automatic test_round_robin();
    int bad = 0, gap = 0, hbad = 0, c = 0, n = 0;
    @(posedge clk_i); #1;
    done_r = 4'hF; enable_i = 4'hF; mix = 1'b1; tready_i = 1'b1;
    apply_reset();
    clear_mon();
    while (nlast < 4 && c < 10000) begin
      @(negedge clk_i); c++;
    end
    repeat (3) @(negedge clk_i);
    checks++; if (nlast !== 4) begin failures++; $display("FAIL rr_timeout got=%0d exp=4", nlast); end
    checks++; if (q_data.size() !== 4 * (NW + 1)) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", q_data.size(), 4 * (NW + 1)); end
    for (int p = 0; p < 4; p++) begin
      int base = p * (NW + 1);
      if (base < q_data.size() && q_data[base] !== {4'hA, 2'(p), 10'(p), 16'(NW)}) hbad++;
      for (int k = 0; k < NW && base + k + 1 < q_data.size(); k++) begin
        if (q_data[base+k+1] !== {2'(p), 19'd0, 11'(k)} || q_last[base+k+1] !== (k == NW - 1)) bad++;
        if (q_cyc[base+k+1] - q_cyc[base] != k + 1) gap++;
      end
    end
    checks++; if (hbad !== 0) begin failures++; $display("FAIL rr_headers got=%0d bad exp=0", hbad); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rr_data got=%0d bad exp=0", bad); end
    checks++; if (gap !== 0) begin failures++; $display("FAIL rr_gaps got=%0d exp=0", gap); end
    foreach (q_sent[i]) if (q_sent[i] !== 4'(1 << i)) n++;
    checks++; if (q_sent.size() !== 4 || n !== 0) begin failures++; $display("FAIL rr_lab_sent got=%0d pulses %0d wrong exp=4/0", q_sent.size(), n); end
    repeat (100) @(negedge clk_i);
    checks++; if (q_data.size() !== 4 * (NW + 1)) begin failures++; $display("FAIL rr_no_repeat got=%0d exp=%0d", q_data.size(), 4 * (NW + 1)); end
  endtask

  task automatic test_random_ready();
    int bad = 0, unst = 0, c = 0;
    logic stall = 1'b0, sl = 1'b0;
    logic [31:0] sd = 32'd0;
    @(posedge clk_i); #1 done_r = 4'd0;
    repeat (20) @(posedge clk_i);
    #1 clear_mon();
    done_r = 4'b1000;
    while (nlast < 1 && c < 12000) begin
      @(posedge clk_i); #1 tready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i); c++;
      if (stall && (tvalid_o !== 1'b1 || tdata_o !== sd || tlast_o !== sl)) unst++;
      stall = tvalid_o && !tready_i;
      sd = tdata_o;
      sl = tlast_o;
    end
    @(posedge clk_i); #1 tready_i = 1'b1;
    checks++; if (nlast !== 1) begin failures++; $display("FAIL rand_timeout got=%0d exp=1", nlast); end
    checks++; if (q_data.size() !== NW + 1) begin failures++; $display("FAIL rand_len got=%0d exp=%0d", q_data.size(), NW + 1); end
    checks++; if (q_data[0] !== 32'hAC04_0600) begin failures++; $display("FAIL rand_hdr got=%h exp=ac040600", q_data[0]); end
    for (int k = 0; k < NW && k + 1 < q_data.size(); k++)
      if (q_data[k+1] !== {2'd3, 19'd0, 11'(k)} || q_last[k+1] !== (k == NW - 1)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rand_data got=%0d bad exp=0", bad); end
    checks++; if (unst !== 0) begin failures++; $display("FAIL rand_hold got=%0d unstable exp=0", unst); end
  endtask

  task automatic test_reset_mid();
    int bad = 0, c = 0;
    logic found = 1'b0;
    logic [1:0] p0 = 2'd3, p2 = 2'd3;
    @(posedge clk_i); #1;
    done_r = 4'b0010; enable_i = 4'hF; mix = 1'b1; tready_i = 1'b1;
    apply_reset();
    while (!found && c < 3000) begin
      @(negedge clk_i); c++;
      found = busy_o && addr_o[12:11] == 2'd1 && addr_o[10:0] == 11'd700;
    end
    #1 rst_n_i = 1'b0;
    #1;
    checks++; if (!found) begin failures++; $display("FAIL mid_reach700 got=0 exp=1"); end
    checks++; if (tvalid_o !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%0b exp=0", tvalid_o); end
    checks++; if (addr_o !== 13'd0) begin failures++; $display("FAIL mid_addr got=%h exp=0", addr_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy_o); end
    clear_mon();
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    c = 0;
    while (nlast < 1 && c < 4000) begin
      @(negedge clk_i); c++;
      if (c == 1) p0 = addr_o[12:11];
      if (c == 3) p2 = addr_o[12:11];
    end
    checks++; if (p0 !== 2'd0 || p2 !== 2'd1) begin failures++; $display("FAIL mid_poll_order got=%0d,%0d exp=0,1", p0, p2); end
    checks++; if (nlast !== 1) begin failures++; $display("FAIL mid_timeout got=%0d exp=1", nlast); end
    checks++; if (q_data.size() !== NW + 1) begin failures++; $display("FAIL mid_len got=%0d exp=%0d", q_data.size(), NW + 1); end
    checks++; if (q_data[0] !== 32'hA400_0600) begin failures++; $display("FAIL mid_hdr got=%h exp=a4000600", q_data[0]); end
    for (int k = 0; k < NW && k + 1 < q_data.size(); k++)
      if (q_data[k+1] !== {2'd1, 19'd0, 11'(k)}) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL mid_data got=%0d bad exp=0", bad); end
  endtask

  task automatic test_stall_lat2();
    int bad = 0, unst = 0, maxbuf = 0, nb = 0, c = 0;
    logic [31:0] sd;
    @(posedge clk_i); #1;
    clear_mon();
    mix = 1'b1; enable2 = 4'b0001; done2_r = 4'b0001; tready2 = 1'b1;
    while (q2_data.size() < 501 && c < 4000) begin
      @(negedge clk_i); c++;
    end
    checks++; if (q2_data.size() < 501) begin failures++; $display("FAIL stall_reach got=%0d exp=501", q2_data.size()); end
    @(posedge clk_i); #1 tready2 = 1'b0;
    @(negedge clk_i);
    sd = tdata2;
    repeat (100) begin
      @(negedge clk_i);
      nb = int'(addr2[10:0]) - (q2_data.size() - 1);
      if (nb > maxbuf) maxbuf = nb;
      if (tvalid2 !== 1'b1 || tdata2 !== sd || busy2 !== 1'b1) unst++;
    end
    checks++; if (maxbuf !== 4) begin failures++; $display("FAIL stall_buffered got=%0d exp=4", maxbuf); end
    checks++; if (unst !== 0) begin failures++; $display("FAIL stall_hold got=%0d unstable exp=0", unst); end
    @(posedge clk_i); #1 tready2 = 1'b1;
    c = 0;
    while (nlast2 < 1 && c < 4000) begin
      @(negedge clk_i); c++;
    end
    repeat (3) @(negedge clk_i);
    checks++; if (nlast2 !== 1) begin failures++; $display("FAIL stall_timeout got=%0d exp=1", nlast2); end
    checks++; if (q2_data.size() !== NW + 1) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", q2_data.size(), NW + 1); end
    checks++; if (q2_data[0] !== 32'hA000_0600) begin failures++; $display("FAIL stall_hdr got=%h exp=a0000600", q2_data[0]); end
    for (int k = 0; k < NW && k + 1 < q2_data.size(); k++)
      if (q2_data[k+1] !== {21'd0, 11'(k)} || q2_last[k+1] !== (k == NW - 1)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL stall_data got=%0d bad exp=0", bad); end
    checks++; if (sent2_or !== 4'b0001) begin failures++; $display("FAIL stall_lab_sent got=%b exp=0001", sent2_or); end
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_single();
    test_rearm();
    test_round_robin();
    test_random_ready();
    test_reset_mid();
    test_stall_lat2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
